// File: rtl/leg4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : leg4_pkg                                                |
// | Desc     : Shared constants and types for the leg4 program loader. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package leg4_pkg;

   localparam int ADR_W = 4;
   localparam int DAT_W = 8;
   localparam int NIB_W = 4;
   localparam int DEPTH = 2 ** ADR_W;

   // Loader states: waiting for high nibble, waiting for low nibble, clear sweep
   typedef enum logic [1:0] {
      ST_HI  = 2'd0,
      ST_LO  = 2'd1,
      ST_CLR = 2'd2
   } state_t;

   // Program memory image at the default geometry
   typedef logic [DAT_W-1:0] mem_t [DEPTH];

endpackage
`default_nettype wire

// File: rtl/leg4_edge_rise.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : leg4_edge_rise                                          |
// | Desc     : One-flop rising-edge detector for debounced buttons.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module leg4_edge_rise (
   input  logic clk,
   input  logic nrst,
   input  logic in,
   output logic rise
);

   logic in_q;

   // Remember the previous level so a held button yields a single pulse
   always_ff @(posedge clk) begin
      if (!nrst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign rise = in & ~in_q;

endmodule
`default_nettype wire

// File: rtl/leg4_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : leg4_prog_loader                                        |
// | Desc     : Writable 16x8 program memory for leg4. Bytes are        |
// |            entered high nibble first from the switches; the CPU    |
// |            side reads combinationally like the fixed ROM.          |
// |            Define PROG_CLEAR_EN to build the clear-all sweep.      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module leg4_prog_loader
   import leg4_pkg::state_t, leg4_pkg::ST_HI, leg4_pkg::ST_LO, leg4_pkg::ST_CLR;
#(
   parameter int ADR_W = leg4_pkg::ADR_W,
   parameter int DAT_W = leg4_pkg::DAT_W,
   parameter int NIB_W = leg4_pkg::NIB_W
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             load_mode,
   input  logic             wr_btn,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             clr_req,
   input  logic [ADR_W-1:0] rd_adr,
   output logic [DAT_W-1:0] rd_data,
   output logic [ADR_W-1:0] edit_adr,
   output logic [DAT_W-1:0] edit_data,
   output logic             lo_phase,
   output logic             busy
);

   localparam int DEPTH = 2 ** ADR_W;
   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

   logic [DAT_W-1:0] mem [DEPTH];

   state_t           state;
   logic [ADR_W-1:0] wptr;
   logic [NIB_W-1:0] hi_reg;
   logic             wr_rise;
   logic             clr_take;
   logic             mem_we;
   logic [DAT_W-1:0] mem_wdata;

   leg4_edge_rise u_wr_edge (
      .clk  (clk),
      .nrst (nrst),
      .in   (wr_btn),
      .rise (wr_rise)
   );

`ifdef PROG_CLEAR_EN
   logic busy_r;

   // A clear request outranks a simultaneous button press and is ignored mid-sweep
   assign clr_take = clr_req & load_mode & (state != ST_CLR);
   assign busy     = busy_r;
`else
   logic unused_clr;

   assign unused_clr = clr_req;
   assign clr_take   = 1'b0;
   assign busy       = 1'b0;
`endif

   // Decide whether this edge writes memory and with what byte
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = {hi_reg, nib_in};
      if (nrst) begin
         case (state)
            ST_LO: begin
               if (load_mode && wr_rise && !clr_take) begin
                  mem_we = 1'b1;
               end
            end
`ifdef PROG_CLEAR_EN
            ST_CLR: begin
               mem_we    = 1'b1;
               mem_wdata = '0;
            end
`endif
            default: begin
               mem_we = 1'b0;
            end
         endcase
      end
   end

   // Program storage: not reset, so a CPU reset keeps the loaded program
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr] <= mem_wdata;
      end
   end

   // Loader FSM with registered phase/busy flags
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= ST_HI;
         wptr     <= '0;
         hi_reg   <= '0;
         lo_phase <= 1'b0;
`ifdef PROG_CLEAR_EN
         busy_r   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_HI: begin
               if (clr_take) begin
                  state    <= ST_CLR;
                  wptr     <= '0;
                  hi_reg   <= '0;
`ifdef PROG_CLEAR_EN
                  busy_r   <= 1'b1;
`endif
               end else if (load_mode && wr_rise) begin
                  hi_reg   <= nib_in;
                  state    <= ST_LO;
                  lo_phase <= 1'b1;
               end
            end
            ST_LO: begin
               if (clr_take) begin
                  state    <= ST_CLR;
                  wptr     <= '0;
                  hi_reg   <= '0;
                  lo_phase <= 1'b0;
`ifdef PROG_CLEAR_EN
                  busy_r   <= 1'b1;
`endif
               end else if (!load_mode) begin
                  // Leaving edit mode abandons the half-entered byte
                  state    <= ST_HI;
                  hi_reg   <= '0;
                  lo_phase <= 1'b0;
               end else if (wr_rise) begin
                  wptr     <= wptr + ADR_W'(1);
                  state    <= ST_HI;
                  lo_phase <= 1'b0;
               end
            end
`ifdef PROG_CLEAR_EN
            ST_CLR: begin
               wptr <= wptr + ADR_W'(1);
               if (wptr == LAST_ADR) begin
                  state  <= ST_HI;
                  busy_r <= 1'b0;
               end
            end
`endif
            default: begin
               state    <= ST_HI;
               lo_phase <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data   = mem[rd_adr];
   assign edit_adr  = wptr;
   assign edit_data = mem[wptr];

endmodule
`default_nettype wire

// File: tb/tb_leg4_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_leg4_prog_loader                                     |
// | Desc     : Directed self-checking bench for leg4_prog_loader.      |
// |            Clear-sweep sequences build only with PROG_CLEAR_EN.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_leg4_prog_loader;

   logic       clk = 1'b0;
   logic       nrst;
   logic       load_mode;
   logic       wr_btn;
   logic [3:0] nib_in;
   logic       clr_req;
   logic [3:0] rd_adr;
   logic [7:0] rd_data;
   logic [3:0] edit_adr;
   logic [7:0] edit_data;
   logic       lo_phase;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] hi;
      logic [3:0] lo;
      logic [3:0] exp_adr;
      logic [7:0] exp_data;
   } byte_vec_t;

   byte_vec_t vecs [16];

   leg4_prog_loader dut (
      .clk       (clk),
      .nrst      (nrst),
      .load_mode (load_mode),
      .wr_btn    (wr_btn),
      .nib_in    (nib_in),
      .clr_req   (clr_req),
      .rd_adr    (rd_adr),
      .rd_data   (rd_data),
      .edit_adr  (edit_adr),
      .edit_data (edit_data),
      .lo_phase  (lo_phase),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] nib);
      nib_in = nib;
      wr_btn = 1'b1;
      step();
      wr_btn = 1'b0;
      step();
   endtask

   task automatic chk_mem(input string name, input logic [3:0] adr, input logic [7:0] exp);
      rd_adr = adr;
      #1;
      chk(name, {24'd0, rd_data}, {24'd0, exp});
   endtask

`ifdef PROG_CLEAR_EN
   task automatic fill_ff();
      for (int i = 0; i < 16; i++) begin
         press(4'hF);
         press(4'hF);
      end
   endtask
`endif

   initial begin
      nrst      = 1'b0;
      load_mode = 1'b0;
      wr_btn    = 1'b0;
      nib_in    = 4'h0;
      clr_req   = 1'b0;
      rd_adr    = 4'h0;

      for (int i = 0; i < 16; i++) begin
         vecs[i].hi       = 4'h0;
         vecs[i].lo       = 4'(i);
         vecs[i].exp_adr  = 4'(i + 1);
         vecs[i].exp_data = 8'(i);
      end

      // Power-up and reset
      step();
      step();
      nrst = 1'b1;
      step();
      chk("reset_edit_adr", {28'd0, edit_adr}, 32'd0);
      chk("reset_lo_phase", {31'd0, lo_phase}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      for (int a = 0; a < 16; a++) chk_mem("powerup_mem", 4'(a), 8'h00);

      // First byte A5 at address 0
      load_mode = 1'b1;
      press(4'hA);
      chk("a5_lo_phase_hi", {31'd0, lo_phase}, 32'd1);
      press(4'h5);
      chk("a5_lo_phase_lo", {31'd0, lo_phase}, 32'd0);
      chk("a5_edit_adr", {28'd0, edit_adr}, 32'd1);
      chk_mem("a5_mem0", 4'h0, 8'hA5);
      chk("a5_edit_data", {24'd0, edit_data}, 32'h00);

      // Held button captures a single nibble
      nib_in = 4'hB;
      wr_btn = 1'b1;
      repeat (100) step();
      chk("hold_lo_phase", {31'd0, lo_phase}, 32'd1);
      chk("hold_edit_adr", {28'd0, edit_adr}, 32'd1);
      wr_btn = 1'b0;
      step();
      press(4'hC);
      chk("hold_edit_adr2", {28'd0, edit_adr}, 32'd2);
      chk_mem("hold_mem1", 4'h1, 8'hBC);

      // Reset keeps memory and returns the pointer to 0
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      chk("rst_edit_adr", {28'd0, edit_adr}, 32'd0);
      chk_mem("rst_keep0", 4'h0, 8'hA5);
      chk_mem("rst_keep1", 4'h1, 8'hBC);

      // Table: 16 bytes 00..0F, pointer wraps back to 0
      for (int i = 0; i < 16; i++) begin
         press(vecs[i].hi);
         chk("tbl_lo_phase", {31'd0, lo_phase}, 32'd1);
         press(vecs[i].lo);
         chk("tbl_edit_adr", {28'd0, edit_adr}, {28'd0, vecs[i].exp_adr});
         chk_mem("tbl_mem", 4'(i), vecs[i].exp_data);
      end

      // 17th byte overwrites address 0; old value visible until the write edge
      press(4'hE);
      rd_adr = 4'h0;
      nib_in = 4'h1;
      wr_btn = 1'b1;
      #1;
      chk("rdw_old", {24'd0, rd_data}, 32'h00);
      step();
      chk("rdw_new", {24'd0, rd_data}, 32'hE1);
      chk("wrap_edit_adr", {28'd0, edit_adr}, 32'd1);
      chk("wrap_edit_data", {24'd0, edit_data}, 32'h01);
      wr_btn = 1'b0;
      step();

      // Dropping load_mode in LO discards the high nibble
      press(4'h3);
      load_mode = 1'b0;
      step();
      chk("drop_lo_phase", {31'd0, lo_phase}, 32'd0);
      press(4'h9);
      press(4'h9);
      chk("run_lo_phase", {31'd0, lo_phase}, 32'd0);
      chk("run_edit_adr", {28'd0, edit_adr}, 32'd1);
      chk_mem("run_mem1", 4'h1, 8'h01);
      load_mode = 1'b1;
      step();
      press(4'h7);
      press(4'h1);
      chk_mem("resume_mem1", 4'h1, 8'h71);
      chk("resume_edit_adr", {28'd0, edit_adr}, 32'd2);

      // Reset with a half-entered byte writes nothing
      press(4'h6);
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      chk("halfrst_lo_phase", {31'd0, lo_phase}, 32'd0);
      chk("halfrst_edit_adr", {28'd0, edit_adr}, 32'd0);
      chk_mem("halfrst_mem2", 4'h2, 8'h02);
      chk_mem("halfrst_mem0", 4'h0, 8'hE1);
      press(4'h8);
      press(4'h8);
      chk_mem("after_rst_mem0", 4'h0, 8'h88);

`ifdef PROG_CLEAR_EN
      // Clear requested from LO phase; button presses ignored during sweep
      fill_ff();
      chk_mem("ff_mem5", 4'h5, 8'hFF);
      press(4'hF);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("clr_busy", {31'd0, busy}, 32'd1);
         chk("clr_sweep_adr", {28'd0, edit_adr}, 32'(k));
         wr_btn = k[0];
         step();
      end
      wr_btn = 1'b0;
      chk("clr_done_busy", {31'd0, busy}, 32'd0);
      chk("clr_done_adr", {28'd0, edit_adr}, 32'd0);
      chk("clr_done_lo", {31'd0, lo_phase}, 32'd0);
      for (int a = 0; a < 16; a++) chk_mem("clr_mem", 4'(a), 8'h00);

      // Clear and button press in the same cycle: clear wins
      step();
      nib_in  = 4'h4;
      wr_btn  = 1'b1;
      clr_req = 1'b1;
      step();
      wr_btn  = 1'b0;
      clr_req = 1'b0;
      chk("race_busy", {31'd0, busy}, 32'd1);
      chk("race_lo_phase", {31'd0, lo_phase}, 32'd0);
      repeat (16) step();
      chk("race_done_busy", {31'd0, busy}, 32'd0);
      chk("race_done_lo", {31'd0, lo_phase}, 32'd0);

      // Reset mid-sweep after 8 cleared addresses
      fill_ff();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (8) step();
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_edit_adr", {28'd0, edit_adr}, 32'd0);
      for (int a = 0; a < 16; a++) chk_mem("abort_mem", 4'(a), (a < 8) ? 8'h00 : 8'hFF);
`else
      // Without the clear feature, clr_req has no effect
      clr_req = 1'b1;
      step();
      step();
      clr_req = 1'b0;
      chk("noclr_busy", {31'd0, busy}, 32'd0);
      chk_mem("noclr_mem0", 4'h0, 8'h88);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/leg4_prog_loader.md
Name: leg4_prog_loader

Overview:
- Writable 16x8 program memory for the leg4 CPU.
- Write side: the operator enters bytes nibble-by-nibble from the 4-bit switches and a debounced write button.
- Read side: drop-in for the fixed program ROM. The CPU address in gives the instruction byte out, combinationally.
- Sits between the debounce/switch inputs and leg4; the display mux shows edit address/data during loading.

Parameters:
ADR_W, 4, program address width; depth = 2**ADR_W
DAT_W, 8, instruction width; must be 2*NIB_W
NIB_W, 4, switch/nibble width

Ports:
clk        input   1       system clock (12 MHz)
nrst       input   1       reset, synchronous, active-low
load_mode  input   1       1 = editing enabled; 0 = run (writes ignored)
wr_btn     input   1       debounced write button level; block edge-detects
nib_in     input   NIB_W   nibble from switches
clr_req    input   1       clear-all request (PROG_CLEAR_EN only; otherwise ignored)
rd_adr     input   ADR_W   CPU instruction address
rd_data    output  DAT_W   mem[rd_adr], combinational
edit_adr   output  ADR_W   current write pointer
edit_data  output  DAT_W   mem[edit_adr], combinational, for display
lo_phase   output  1       1 = high nibble held, awaiting low nibble
busy       output  1       1 during clear sweep

Behaviour:
- All sequential logic on posedge clk.
- Reset is synchronous active-low: nrst sampled low at an edge gives:
  - wptr=0, state=HI, hi_reg=0, btn_q=0, busy=0, lo_phase=0.
- Memory is NOT affected by nrst, so a CPU reset keeps the loaded program. Power-up content is all 8'h00.
- Edge detect: btn_q <= wr_btn; wr_rise = wr_btn & ~btn_q. One write event per press; holding the button gives no repeat.
- FSM states: HI, LO, CLR.
  - HI: if load_mode & wr_rise, then hi_reg <= nib_in and go to LO.
  - LO: if load_mode & wr_rise:
    - mem[wptr] <= {hi_reg, nib_in}
    - wptr <= wptr+1, wrapping 15 to 0
    - go to HI.
  - LO: if load_mode==0, go to HI and discard hi_reg (no write).
  - CLR: see Optional Feature.
- load_mode==0 in HI: no state change; wr_rise is ignored, but btn_q still tracks wr_btn.
- Write latency: new byte is visible on rd_data/edit_data the cycle after the write edge.
- Read during write to the same address: rd_data shows the old value until the edge.
- lo_phase = (state==LO). busy = (state==CLR).
- wptr is only changed by writes, clear, or reset. Toggling load_mode does not reset wptr; re-entry resumes at the same address.
- A reset in LO drops the half-entered byte. Memory is unchanged.

Optional Feature:
Macro: PROG_CLEAR_EN
- Defined:
  - clr_req==1 with load_mode==1 in HI or LO causes: state <= CLR, wptr <= 0, hi_reg discarded.
  - In CLR, each cycle: mem[wptr] <= 0 and wptr <= wptr+1.
  - After writing address 15: wptr wraps to 0 and state goes to HI.
  - The sweep takes exactly 16 cycles; busy=1 throughout.
  - During CLR, wr_rise, clr_req and load_mode are ignored; the sweep always completes.
  - rd_data stays live and shows partially cleared memory.
  - If clr_req and wr_rise arrive in the same cycle, clr_req wins and no nibble is captured.
  - nrst low mid-sweep aborts to HI with wptr=0; addresses already cleared stay cleared.
- Undefined:
  - CLR state is not compiled; clr_req is unused and busy is tied to 0.

Decomposition:
- Shared package leg4_pkg:
  - ADR_W/DAT_W/NIB_W constants
  - FSM state typedef (ST_HI, ST_LO, ST_CLR)
  - 16-entry memory array type
- One sub-module, leg4_edge_rise: one-flop rising-edge detector (clk, nrst, in, rise). It is reusable for clk_btn stepping elsewhere.
- Memory stays inline as a register array: async read, sync write.

Test Plan:
1. Power-up plus reset, no writes -> rd_data=00 for rd_adr 0..15; edit_adr=0; lo_phase=0; busy=0.
2. load_mode=1; pulse wr_btn with nib_in=A, then with nib_in=5 -> mem[0]=A5; rd_adr=0 gives A5 next cycle; edit_adr=1; lo_phase toggles 1 then 0.
3. Hold wr_btn high for 100 cycles -> exactly one nibble captured. Enter 16 full bytes 00..0F -> wptr wraps to 0; 17th byte overwrites address 0.
4. Enter high nibble 3, drop load_mode, raise load_mode, enter 7 then 1 -> mem[wptr]=71; nibble 3 discarded. With load_mode=0, presses change nothing.
5. Load program, pulse nrst low 1 cycle -> memory intact, wptr=0, state HI. Half-entered byte before reset -> not written.
6. (PROG_CLEAR_EN) memory full of FF, clr_req in LO phase:
   -> busy=1 for exactly 16 cycles and wr_btn pulses ignored.
   -> all 00 afterwards; wptr=0.
   -> clr_req and wr_rise in the same cycle: clear taken.
   -> nrst mid-sweep at cycle 8: addresses 0..7 = 00, 8..15 = FF.
